mem_bus_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory bus
//               arbiter: FSM state encoding, default bus widths and the
//               requester index constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Default memory bus widths
  localparam int c_DEFAULT_ADDR_W = 16;
  localparam int c_DEFAULT_DATA_W = 16;

  // Requester indices
  localparam logic c_PORT_CPU    = 1'b0;
  localparam logic c_PORT_LOADER = 1'b1;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker. When both
//               requesters are eligible the one that was not granted last
//               wins; otherwise the single eligible requester is chosen.
// Ports       : eligible[1:0] - per-port eligibility
//               last_grant    - index of the most recent grant
//               grant_valid   - at least one port is eligible
//               grant_idx     - index of the chosen port
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    grant_idx   = c_PORT_CPU;
    if (eligible == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (eligible[1]) begin
      grant_idx = c_PORT_LOADER;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Arbitrates a single-port synchronous-read memory between the
//               CPU load/store port (m0) and the debug/program loader (m1).
//               Every transaction walks IDLE -> ACCESS -> RESP, issuing
//               exactly one memory command, and completes with a one-cycle
//               ack three cycles after the request is accepted.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               mX_req/we/addr/wdata     - requester X command (held until ack)
//               mX_ack, mX_rdata         - completion pulse, held read data
//               mem_en/we/addr/wdata     - memory command outputs
//               mem_rdata                - memory read data (1-cycle latency)
//               owner                    - index of the most recent grant
//               busy                     - sequencer not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = c_DEFAULT_ADDR_W,
  parameter int DATA_W = c_DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (CPU)
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  // requester 1 (loader)
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              owner,
  output logic              busy
);

  arb_state_e        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q,      owner_d;
  logic              lat_we_q,     lat_we_d;
  logic              mem_en_q,     mem_en_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [1:0]        ack_q,        ack_d;
  logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;
  logic              busy_q,       busy_d;

  logic [1:0]        w_eligible;
  logic              w_grant_valid;
  logic              w_grant_idx;

  // A port whose ack is high this cycle is still holding its old request;
  // masking it keeps that request from being granted a second time.
  assign w_eligible = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};

  rr_pick2 u_pick (
    .eligible    (w_eligible),
    .last_grant  (last_grant_q),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lat_we_d     = lat_we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ack_d        = 2'b00;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_valid) begin
          state_d      = ST_ACCESS;
          owner_d      = w_grant_idx;
          last_grant_d = w_grant_idx;
          // The address/data registers double as the request latches, so
          // the memory command outputs are registered and hold afterwards.
          lat_we_d     = w_grant_idx ? m1_we    : m0_we;
          mem_addr_d   = w_grant_idx ? m1_addr  : m0_addr;
          mem_wdata_d  = w_grant_idx ? m1_wdata : m0_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = w_grant_idx ? m1_we    : m0_we;
        end
      end

      ST_ACCESS: begin
        state_d = ST_RESP;
      end

      ST_RESP: begin
        // Memory data for the ACCESS-cycle command is valid now.
        state_d = ST_IDLE;
        if (owner_q) begin
          ack_d[1] = 1'b1;
          if (!lat_we_q) m1_rdata_d = mem_rdata;
        end else begin
          ack_d[0] = 1'b1;
          if (!lat_we_q) m0_rdata_d = mem_rdata;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= c_PORT_LOADER;  // port 0 wins the first contention
      owner_q      <= c_PORT_CPU;
      lat_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack_q        <= 2'b00;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lat_we_q     <= lat_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack_q        <= ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule : mem_bus_arbiter
`default_nettype wire
